// File: rtl/mod_mul_pm_if.sv
// Request/result bundle for the pseudo-Mersenne modular multiplier.
interface mod_mul_pm_if #(
  parameter int unsigned W = 256
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] r;

  // Requester side: drives operands, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, r
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output busy, done, r
  );
endinterface

// File: rtl/mod_mul_pm.sv
// Fused modular multiplier: R = (A*B) mod P with P = 2^W - C.
// Limb-serial schoolbook product, two folds against C, and one conditional subtract.
// Every operation takes the same number of cycles regardless of operand values.
module mod_mul_pm #(
  parameter int unsigned    W    = 256,
  parameter int unsigned    LIMB = 64,
  parameter int unsigned    CW   = 33,
  parameter logic [CW-1:0]  C    = 33'h1000003D1
) (
  input  logic       clk,
  input  logic       rst,
  mod_mul_pm_if.slave bus
);

  localparam int unsigned N    = W / LIMB;
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW   = 2 * W;
  localparam int unsigned SW   = $clog2(AW);
  localparam int unsigned PW   = 2 * LIMB;
  localparam int unsigned FW   = W + CW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  // Modulus widened by one bit so the final compare sees the carry out of FOLD2.
  localparam logic [W:0]  P_EXT = {1'b1, {W{1'b0}}} - (W+1)'(C);

  // Parameter sanity: limbs must tile W, and two folds must suffice for reduction.
  if (((W % LIMB) != 0) || ((2 * CW + 1) >= W)) begin : g_bad_param
    $error("mod_mul_pm: illegal parameters (need W %% LIMB == 0 and 2*CW+1 < W)");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_FOLD1,
    S_FOLD2,
    S_CSUB
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [AW-1:0]   acc_q;
  logic [IW-1:0]   i_q;
  logic [IW-1:0]   j_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    r_q;

  logic [LIMB-1:0] a_limb;
  logic [LIMB-1:0] b_limb;
  logic [PW-1:0]   prod;
  logic [SW-1:0]   shamt;
  logic [AW-1:0]   mul_acc_d;
  logic [FW-1:0]   fold_prod;
  logic [AW-1:0]   fold_acc_d;
  logic [W:0]      red;
  logic [W-1:0]    r_d;

  // Datapath: one limb product per MUL cycle, the fold step, and the final subtract.
  always_comb begin
    a_limb     = a_q[i_q*LIMB +: LIMB];
    b_limb     = b_q[j_q*LIMB +: LIMB];
    prod       = PW'(a_limb) * PW'(b_limb);
    shamt      = SW'((32'(i_q) + 32'(j_q)) * LIMB);
    mul_acc_d  = acc_q + (AW'(prod) << shamt);
    // High half times C folds 2^W back into the low half (2^W == C mod P).
    fold_prod  = FW'(acc_q[AW-1:W]) * FW'(C);
    fold_acc_d = AW'(acc_q[W-1:0]) + AW'(fold_prod);
    // After two folds the value is below 2P, so one subtract fully reduces it.
    red        = acc_q[W:0];
    r_d        = (red >= P_EXT) ? W'(red - P_EXT) : W'(red);
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
              state_q <= S_FOLD1;
            end else begin
              i_q <= i_q + IW'(1);
            end
          end else begin
            j_q <= j_q + IW'(1);
          end
        end
        S_FOLD1: begin
          acc_q   <= fold_acc_d;
          state_q <= S_FOLD2;
        end
        S_FOLD2: begin
          acc_q   <= fold_acc_d;
          state_q <= S_CSUB;
        end
        S_CSUB: begin
          r_q     <= r_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.r    = r_q;

endmodule

// File: tb/tb_mod_mul_pm.sv
// Directed bench for mod_mul_pm: secp256k1 default config plus a W=64 build.
module tb_mod_mul_pm;

  localparam logic [255:0] C0 = 256'h1000003D1;
  localparam logic [255:0] P0 =
    256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  mod_mul_pm_if #(.W(256)) bus0 ();
  mod_mul_pm_if #(.W(64))  bus1 ();

  mod_mul_pm u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mod_mul_pm #(
    .W    (64),
    .LIMB (16),
    .CW   (6),
    .C    (6'd59)
  ) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation on the default instance; call at #1 after a posedge while idle.
  task automatic do_op(input logic [255:0] av, input logic [255:0] bv,
                       output logic [255:0] res, output int lat, output int bcyc);
    bus0.start = 1'b1;
    bus0.a     = av;
    bus0.b     = bv;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    lat  = 0;
    bcyc = bus0.busy ? 1 : 0;
    while (!bus0.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus0.busy) bcyc++;
    end
    check_eq("done_seen", 256'(bus0.done), 256'd1);
    res = bus0.r;
  endtask

  logic [255:0] res;
  int           lat;
  int           bcyc;
  logic [255:0] opa [3];
  logic [255:0] opb [3];
  logic [255:0] rr  [3];
  int           tdone [3];
  int           k;
  int           ovl;
  logic         seen;
  logic [127:0] p64;
  logic [127:0] exp64;
  logic [63:0]  x64;

  initial begin
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus0.a     = '0;
    bus0.b     = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 256'(bus0.busy), 256'd0);
    check_eq("rst_done", 256'(bus0.done), 256'd0);
    check_eq("rst_r",    bus0.r,          256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: zero operand, latency and busy length
    do_op(256'd0, P0 - 256'd1, res, lat, bcyc);
    check_eq("t1_r",    res,           256'd0);
    check_eq("t1_lat",  256'(lat),     256'd19);
    check_eq("t1_busy", 256'(bcyc),    256'd19);
    check_eq("t1_busy_low_at_done", 256'(bus0.busy), 256'd0);

    // 2: (-1)*(-1) = 1
    do_op(P0 - 256'd1, P0 - 256'd1, res, lat, bcyc);
    check_eq("t2_r", res, 256'd1);

    // 3: 2^256 mod P = C
    do_op(256'd1 << 128, 256'd1 << 128, res, lat, bcyc);
    check_eq("t3_r", res, C0);

    // 4: (-1)*2 = P-2
    do_op(P0 - 256'd1, 256'd2, res, lat, bcyc);
    check_eq("t4_r", res, P0 - 256'd2);

    // 5: reset mid-MUL aborts, no stray done
    bus0.start = 1'b1;
    bus0.a     = P0 - 256'd1;
    bus0.b     = P0 - 256'd1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_busy", 256'(bus0.busy), 256'd0);
    check_eq("t5_done", 256'(bus0.done), 256'd0);
    check_eq("t5_r",    bus0.r,          256'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus0.done || bus0.busy) seen = 1'b1;
    end
    check_eq("t5_no_stray", 256'(seen), 256'd0);
    do_op(256'd3, 256'd5, res, lat, bcyc);
    check_eq("t5_r_after", res, 256'd15);

    // 6: start held high, three ops back to back
    opa[0] = 256'd7;          opb[0] = 256'd9;
    opa[1] = P0 - 256'd1;     opb[1] = 256'd1;
    opa[2] = 256'd1 << 255;   opb[2] = 256'd2;
    k   = 0;
    ovl = 0;
    bus0.start = 1'b1;
    bus0.a     = opa[0];
    bus0.b     = opb[0];
    for (int c = 1; c <= 200 && k < 3; c++) begin
      @(posedge clk); #1;
      if (bus0.done && bus0.busy) ovl++;
      if (bus0.done) begin
        rr[k]    = bus0.r;
        tdone[k] = c;
        k++;
        if (k < 3) begin
          bus0.a = opa[k];
          bus0.b = opb[k];
        end else begin
          bus0.start = 1'b0;
        end
      end
    end
    bus0.start = 1'b0;
    check_eq("t6_count", 256'(k), 256'd3);
    if (k == 3) begin
      check_eq("t6_r0",   rr[0], 256'd63);
      check_eq("t6_r1",   rr[1], P0 - 256'd1);
      check_eq("t6_r2",   rr[2], C0);
      check_eq("t6_gap1", 256'(tdone[1] - tdone[0]), 256'd20);
      check_eq("t6_gap2", 256'(tdone[2] - tdone[1]), 256'd20);
    end
    check_eq("t6_overlap", 256'(ovl), 256'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t6_r_held", bus0.r, C0);

    // W=64 build against a bench-side modmul
    x64   = 64'h7FFFFFFFFFFFFFFF;
    p64   = (128'd1 << 64) - 128'd59;
    exp64 = (128'(x64) * 128'(x64)) % p64;
    bus1.start = 1'b1;
    bus1.a     = x64;
    bus1.b     = x64;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    lat = 0;
    while (!bus1.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("w64_done", 256'(bus1.done), 256'd1);
    check_eq("w64_lat",  256'(lat),       256'd19);
    check_eq("w64_r",    256'(bus1.r),    256'(exp64));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
